// File: rtl/number_entry_fsm.sv
// Keypad number entry: collects up to DIGITS BCD digits plus a sign, then runs a
// fixed-length Horner conversion into a signed WIDTH-bit operand.
module number_entry_fsm #(
   parameter int DIGITS = 4,
   parameter int WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         key_valid,
   input  logic [3:0]                   key_code,
   output logic                         ready,
   output logic [4*DIGITS-1:0]          display_bcd,
   output logic [$clog2(DIGITS+1)-1:0]  digit_count,
   output logic                         full,
   output logic                         negative,
   output logic [WIDTH-1:0]             number,
   output logic                         number_valid
);

   localparam int CW = $clog2(DIGITS + 1);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      S_EMPTY   = 2'd0,
      S_ENTRY   = 2'd1,
      S_CONVERT = 2'd2
   } state_t;

   state_t              r_state;
   logic [4*DIGITS-1:0] r_bcd;
   logic [CW-1:0]       r_count;
   logic                r_neg;
   logic [WIDTH-1:0]    r_acc;
   logic [IW-1:0]       r_idx;
   logic [WIDTH-1:0]    r_number;
   logic                r_valid;

   state_t              w_state_next;
   logic [4*DIGITS-1:0] w_bcd_next;
   logic [CW-1:0]       w_count_next;
   logic                w_neg_next;
   logic [WIDTH-1:0]    w_acc_next;
   logic [IW-1:0]       w_idx_next;
   logic [WIDTH-1:0]    w_number_next;
   logic                w_valid_next;

   logic [4*DIGITS-1:0] w_bcd_shl;
   logic [4*DIGITS-1:0] w_bcd_shr;
   logic [3:0]          w_digit;
   logic [WIDTH-1:0]    w_acc_step;
   logic                w_full;

   // A single-digit buffer has no surviving nibbles to shift, so slice it apart here.
   generate
      if (DIGITS == 1) begin : g_shift_one
         assign w_bcd_shl = key_code;
         assign w_bcd_shr = '0;
      end else begin : g_shift_multi
         assign w_bcd_shl = {r_bcd[4*DIGITS-5:0], key_code};
         assign w_bcd_shr = {4'h0, r_bcd[4*DIGITS-1:4]};
      end
   endgenerate

   assign w_digit    = r_bcd[{r_idx, 2'b00} +: 4];
   assign w_acc_step = (r_acc << 3) + (r_acc << 1) + WIDTH'(w_digit);
   assign w_full     = (r_count == CW'(DIGITS));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_EMPTY;
         r_bcd    <= '0;
         r_count  <= '0;
         r_neg    <= 1'b0;
         r_acc    <= '0;
         r_idx    <= '0;
         r_number <= '0;
         r_valid  <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_bcd    <= w_bcd_next;
         r_count  <= w_count_next;
         r_neg    <= w_neg_next;
         r_acc    <= w_acc_next;
         r_idx    <= w_idx_next;
         r_number <= w_number_next;
         r_valid  <= w_valid_next;
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_bcd_next    = r_bcd;
      w_count_next  = r_count;
      w_neg_next    = r_neg;
      w_acc_next    = r_acc;
      w_idx_next    = r_idx;
      w_number_next = r_number;
      w_valid_next  = 1'b0;

      case (r_state)
         S_EMPTY, S_ENTRY: begin
            if (key_valid) begin
               if (key_code < 4'hA) begin
                  if (!w_full) begin
                     w_bcd_next   = w_bcd_shl;
                     w_count_next = r_count + CW'(1);
                     w_state_next = S_ENTRY;
                  end
               end else begin
                  case (key_code)
                     4'hA: begin
                        if (r_state == S_ENTRY) begin
                           w_state_next = S_CONVERT;
                           w_acc_next   = '0;
                           w_idx_next   = IW'(DIGITS - 1);
                        end
                     end
                     4'hB: begin
                        if (r_state == S_ENTRY) begin
                           w_bcd_next   = w_bcd_shr;
                           w_count_next = r_count - CW'(1);
                           if (r_count == CW'(1)) begin
                              w_state_next = S_EMPTY;
                           end
                        end
                     end
                     4'hC: begin
                        w_bcd_next   = '0;
                        w_count_next = '0;
                        w_neg_next   = 1'b0;
                        w_state_next = S_EMPTY;
                     end
                     4'hD: w_neg_next = ~r_neg;
                     default: ;
                  endcase
               end
            end
         end
         S_CONVERT: begin
            // Every nibble is walked, so latency does not depend on how many digits were typed.
            w_acc_next = w_acc_step;
            w_idx_next = r_idx - IW'(1);
            if (r_idx == '0) begin
               w_number_next = r_neg ? (~w_acc_step + WIDTH'(1)) : w_acc_step;
               w_valid_next  = 1'b1;
               w_bcd_next    = '0;
               w_count_next  = '0;
               w_neg_next    = 1'b0;
               w_state_next  = S_EMPTY;
            end
         end
         default: w_state_next = S_EMPTY;
      endcase
   end

   assign ready        = (r_state != S_CONVERT);
   assign display_bcd  = r_bcd;
   assign digit_count  = r_count;
   assign full         = w_full;
   assign negative     = r_neg;
   assign number       = r_number;
   assign number_valid = r_valid;

endmodule

// File: tb/tb_number_entry_fsm.sv
// Bench for number_entry_fsm: directed key sequences followed by random keys,
// all compared every cycle against a digit-queue model of the entry rules.
module tb_number_entry_fsm;

   localparam int DIGITS = 4;
   localparam int WIDTH  = 16;
   localparam int CW     = $clog2(DIGITS + 1);

   logic                clk = 1'b0;
   logic                reset;
   logic                key_valid;
   logic [3:0]          key_code;
   logic                ready;
   logic [4*DIGITS-1:0] display_bcd;
   logic [CW-1:0]       digit_count;
   logic                full;
   logic                negative;
   logic [WIDTH-1:0]    number;
   logic                number_valid;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: digits as typed (oldest first), sign, pending result.
   int unsigned      m_q[$];
   logic             m_neg;
   int               m_busy;
   logic [WIDTH-1:0] m_pending;
   logic [WIDTH-1:0] m_number;
   logic             m_valid;

   number_entry_fsm #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .ready        (ready),
      .display_bcd  (display_bcd),
      .digit_count  (digit_count),
      .full         (full),
      .negative     (negative),
      .number       (number),
      .number_valid (number_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic model_reset();
      m_q.delete();
      m_neg     = 1'b0;
      m_busy    = 0;
      m_pending = '0;
      m_number  = '0;
      m_valid   = 1'b0;
   endtask

   task automatic model_step(input logic kv, input logic [3:0] kc, input logic rst);
      int unsigned v;
      if (rst) begin
         model_reset();
         return;
      end
      m_valid = 1'b0;
      if (m_busy > 0) begin
         m_busy--;
         if (m_busy == 0) begin
            m_number = m_pending;
            m_valid  = 1'b1;
            m_q.delete();
            m_neg    = 1'b0;
         end
      end else if (kv) begin
         if (kc < 4'hA) begin
            if (m_q.size() < DIGITS) m_q.push_back(int'(kc));
         end else if (kc == 4'hA) begin
            if (m_q.size() > 0) begin
               v = 0;
               foreach (m_q[i]) v = v * 10 + m_q[i];
               m_pending = m_neg ? WIDTH'(-int'(v)) : WIDTH'(v);
               m_busy    = DIGITS;
            end
         end else if (kc == 4'hB) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
         end else if (kc == 4'hC) begin
            m_q.delete();
            m_neg = 1'b0;
         end else if (kc == 4'hD) begin
            m_neg = ~m_neg;
         end
      end
   endtask

   task automatic compare_all();
      logic [4*DIGITS-1:0] exp_disp;
      int sz;
      sz = m_q.size();
      exp_disp = '0;
      for (int i = 0; i < sz; i++) exp_disp[i*4 +: 4] = 4'(m_q[sz-1-i]);
      check("ready",        32'(ready),        32'(m_busy == 0));
      check("display_bcd",  32'(display_bcd),  32'(exp_disp));
      check("digit_count",  32'(digit_count),  32'(sz));
      check("full",         32'(full),         32'(sz == DIGITS));
      check("negative",     32'(negative),     32'(m_neg));
      check("number",       32'(number),       32'(m_number));
      check("number_valid", 32'(number_valid), 32'(m_valid));
      if (m_valid) $display("conversion: number=%0h (%0d)", number, $signed(number));
   endtask

   task automatic cycle(input logic kv, input logic [3:0] kc, input logic rst);
      key_valid = kv;
      key_code  = kc;
      reset     = rst;
      @(posedge clk);
      model_step(kv, kc, rst);
      @(negedge clk);
      compare_all();
      key_valid = 1'b0;
      key_code  = 4'h0;
      reset     = 1'b0;
   endtask

   task automatic key(input logic [3:0] kc);
      cycle(1'b1, kc, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0);
   endtask

   initial begin
      logic rst;
      logic kv;
      reset     = 1'b1;
      key_valid = 1'b0;
      key_code  = 4'h0;
      model_reset();
      @(negedge clk);
      cycle(1'b0, 4'h0, 1'b1);
      cycle(1'b0, 4'h0, 1'b1);
      check("reset_ready", 32'(ready), 32'd1);

      // basic entry
      key(4'h1); key(4'h2); key(4'h3);
      check("s1_display", 32'(display_bcd), 32'h0123);
      key(4'hA);
      idle(5);
      check("s1_number", 32'(number), 32'h007B);

      // full buffer
      key(4'h9); key(4'h8); key(4'h7); key(4'h6); key(4'h5);
      check("s2_display", 32'(display_bcd), 32'h9876);
      check("s2_full", 32'(full), 32'd1);
      key(4'hA);
      idle(5);
      check("s2_number", 32'(number), 32'h2694);

      // backspace and sign
      key(4'h4); key(4'h5); key(4'hB); key(4'h7); key(4'hD);
      check("s3_display", 32'(display_bcd), 32'h0047);
      key(4'hA);
      idle(5);
      check("s3_number", 32'(number), 32'hFFD1);

      // ignored keys in EMPTY, then clear
      key(4'hA); key(4'hB); key(4'hE);
      key(4'h3); key(4'hD); key(4'hC);
      check("s4_count", 32'(digit_count), 32'd0);

      // key dropped during conversion
      key(4'h1); key(4'h2); key(4'hA);
      idle(1);
      key(4'h5);
      idle(4);
      check("s5_number", 32'(number), 32'd12);

      // reset mid-conversion
      key(4'h8); key(4'h8); key(4'hA);
      idle(1);
      cycle(1'b0, 4'h0, 1'b1);
      idle(5);
      check("s6_number", 32'(number), 32'd0);

      // random keys
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         kv  = ($urandom_range(0, 99) < 60);
         cycle(kv, 4'($urandom_range(0, 15)), rst);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/number_entry_fsm.md
# number_entry_fsm

Parametrised multi-digit number entry controller for the final-project calculator datapath. It accepts one-cycle key events from the keypad scanner (digits, enter, backspace, clear, sign) and holds up to `DIGITS` BCD digits for the seven-segment display. On enter, it runs a sequential BCD-to-binary (Horner) conversion and presents a signed two's-complement operand to the arithmetic unit with a one-cycle valid pulse. It supersedes the fixed-width single-number input FSM.

## Interface
Parameters:
- `DIGITS`, default 4: maximum digits held; must be ≥1.
- `WIDTH`, default 16: width of `number`; must satisfy 2^(WIDTH-1) > 10^DIGITS − 1.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `key_valid` in 1: one-cycle strobe qualifying `key_code`.
- `key_code` in 4: 0x0–0x9 digit, 0xA enter, 0xB backspace, 0xC clear, 0xD sign toggle, 0xE/0xF ignored.
- `ready` out 1: high in EMPTY/ENTRY; keys are accepted only when high.
- `display_bcd` out 4*DIGITS: entered digits, newest in nibble 0, unused nibbles 0.
- `digit_count` out $clog2(DIGITS+1): number of digits held.
- `full` out 1: `digit_count == DIGITS`.
- `negative` out 1: current sign flag.
- `number` out WIDTH: last converted signed value; holds until the next conversion completes.
- `number_valid` out 1: one-cycle pulse when `number` updates.

## Operation
- States: EMPTY (count 0), ENTRY (count ≥1), CONVERT.
- Reset: state EMPTY. `display_bcd`, `digit_count`, `negative`, `number`, `number_valid`, and `full` are 0. `ready` is 1.
- Digit in EMPTY/ENTRY with count < DIGITS:
  - `display_bcd <= {display_bcd[4*DIGITS-5:0], d}` and count +1.
  - EMPTY → ENTRY.
  - Leading zeros count as digits.
- Digit when `full`: ignored; no state change.
- Backspace in ENTRY:
  - Shift right one nibble with zero fill; count −1.
  - At count 1 → EMPTY.
  - Backspace in EMPTY: ignored.
- Clear in any accepting state: buffer 0, count 0, `negative` 0 → EMPTY.
- Sign toggle in EMPTY/ENTRY: `negative <= ~negative`. Count and buffer are unchanged.
- Enter:
  - In ENTRY → CONVERT; accumulator = 0; digit index = DIGITS−1.
  - In EMPTY: ignored.
- CONVERT:
  - Each cycle: `acc <= acc*10 + display_bcd[index]`, index −1.
  - Always exactly DIGITS steps; unused high nibbles are 0, so they contribute nothing.
- Conversion end:
  - On the final step, `number <= negative ? −result : result`, sized to WIDTH; `number_valid <= 1`.
  - Buffer, count, and `negative` clear → EMPTY.
  - Negative zero yields 0.
- Arithmetic: the accumulator is WIDTH bits unsigned; the ×10 is (acc<<3)+(acc<<1). The parameter constraint guarantees no overflow.
- `key_valid` while `ready`=0 is dropped silently. There is no queueing.
- Only one key event per cycle exists, so there are no simultaneous-event cases.
- `reset` asserted mid-CONVERT: abort. Reset values apply, including `number` = 0, and no `number_valid` pulse is produced.

## Timing
- Key accepted at edge E: buffer, count, flags, and state are visible after E (1-cycle latency).
- Enter accepted at edge E0: `ready` is low after E0 through edge E0+DIGITS.
- `number`/`number_valid` update at edge E0+DIGITS; `ready` returns high after that same edge.
- Conversion latency = DIGITS cycles, independent of digit count.
- `number_valid` is high for exactly one cycle, then returns to 0 unless a new conversion ends.
- `ready`, `full`, and `digit_count` are registered or decoded from registered state. There is no combinational path from `key_*` to any output.

## Test plan
All scenarios use DIGITS=4, WIDTH=16.
1. **Basic entry:** reset; keys 1, 2, 3 → `display_bcd` 0x0123, count 3. Enter → `ready` low 4 cycles; `number` 0x007B with a single `number_valid` pulse; display 0, count 0, `ready` 1.
2. **Full buffer:** keys 9, 8, 7, 6, 5 → fifth key ignored, `full` 1, display 0x9876. Enter → `number` 0x2694.
3. **Backspace and sign:** keys 4, 5, backspace, 7, sign → display 0x0047, `negative` 1. Enter → `number` 0xFFD1 (−47), `negative` cleared.
4. **Ignored keys in EMPTY:** enter, backspace, and 0xE in EMPTY → no output change, no pulse. Then keys 3, sign, clear → count 0, `negative` 0, state EMPTY.
5. **Keys dropped during CONVERT:** keys 1, 2, enter, then digit 5 two cycles later → key dropped; `number` 12, display 0 afterward.
6. **Reset mid-conversion:** keys 8, 8, enter, then assert `reset` on the 2nd CONVERT cycle → no `number_valid` pulse; `number` 0, count 0, `ready` 1.
